// File: rtl/counter_prog_pkg.sv
// Shared constants, state encoding and helpers for the serial programming receiver.
package counter_prog_pkg;

  localparam logic [7:0] CMD_LOAD = 8'h01;
  localparam logic [7:0] CMD_CTRL = 8'h02;
  localparam logic [7:0] CMD_READ = 8'h80;

  localparam int CMD_BITS   = 8;
  localparam int FRAME_BITS = 16;

  localparam logic [3:0] CMD_LAST_BIT   = 4'(CMD_BITS - 1);
  localparam logic [3:0] FRAME_LAST_BIT = 4'(FRAME_BITS - 1);
  // First data rise after which sdo may advance; the fall just after rise 8 must keep bit 7.
  localparam logic [3:0] TX_SHIFT_START = 4'(CMD_BITS + 1);

  localparam logic UP_DN_RST  = 1'b1;
  localparam logic CNT_EN_RST = 1'b0;

  typedef enum logic [2:0] {
    ST_WAIT_CS,
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_EXEC
  } state_e;

  function automatic logic [3:0] bit_cnt_inc(input logic [3:0] cnt);
    return (cnt == 4'hF) ? cnt : cnt + 4'd1;
  endfunction

endpackage

// File: rtl/counter_prog_rx_sync_edge.sv
// N-flop synchronizer for an asynchronous pin with registered level and edge pulses.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              level_q;
  logic              rise_q;
  logic              fall_q;

  // Level, rise and fall all update on the same edge so consumers see them aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[STAGES-2:0], d_i};
      level_q <= sync_q[STAGES-1];
      rise_q  <= sync_q[STAGES-1] & ~level_q;
      fall_q  <= ~sync_q[STAGES-1] & level_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/counter_prog_rx.sv
// Serial programming receiver: decodes 16-bit host frames into counter load/enable/direction
// controls and returns a count snapshot on sdo for READ frames.
module counter_prog_rx
  import counter_prog_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk_in,
  input  logic              sdi_in,
  input  logic              cs_n_in,
  input  logic [DATA_W-1:0] count_in,
  output logic              sdo_out,
  output logic              load_strobe,
  output logic [DATA_W-1:0] load_value,
  output logic              cnt_en,
  output logic              up_dn,
  output logic              frame_err,
  output logic              busy
);

  logic sclk_level_unused;
  logic sclk_rise;
  logic sclk_fall;
  logic cs_level;
  logic cs_rise;
  logic cs_fall;
  logic sdi_level;
  logic sdi_rise_unused;
  logic sdi_fall_unused;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk     (clk),
    .rst     (rst),
    .d_i     (sclk_in),
    .level_o (sclk_level_unused),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk     (clk),
    .rst     (rst),
    .d_i     (cs_n_in),
    .level_o (cs_level),
    .rise_o  (cs_rise),
    .fall_o  (cs_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sdi (
    .clk     (clk),
    .rst     (rst),
    .d_i     (sdi_in),
    .level_o (sdi_level),
    .rise_o  (sdi_rise_unused),
    .fall_o  (sdi_fall_unused)
  );

  state_e            state_q;
  logic [3:0]        bit_cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_d;
  logic [DATA_W-1:0] cmd_q;
  logic [DATA_W-1:0] tx_q;
  logic              sdo_q;
  logic              load_strobe_q;
  logic [DATA_W-1:0] load_value_q;
  logic              cnt_en_q;
  logic              up_dn_q;
  logic              frame_err_q;

  assign shift_d = {shift_q[DATA_W-2:0], sdi_level};

  // shift_q, cmd_q and tx_q are pure datapath: reset leaves them alone and IDLE clears shift_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_WAIT_CS;
      bit_cnt_q     <= 4'd0;
      sdo_q         <= 1'b0;
      load_strobe_q <= 1'b0;
      load_value_q  <= '0;
      cnt_en_q      <= CNT_EN_RST;
      up_dn_q       <= UP_DN_RST;
      frame_err_q   <= 1'b0;
    end else begin
      load_strobe_q <= 1'b0;
      frame_err_q   <= 1'b0;
      case (state_q)
        ST_WAIT_CS: begin
          if (cs_level) state_q <= ST_IDLE;
        end
        ST_IDLE: begin
          if (cs_fall) begin
            state_q   <= ST_CMD;
            bit_cnt_q <= 4'd0;
            shift_q   <= '0;
          end
        end
        ST_CMD, ST_DATA: begin
          // Abort has priority, even over a coincident final sclk rise.
          if (cs_rise) begin
            frame_err_q <= 1'b1;
            sdo_q       <= 1'b0;
            state_q     <= ST_IDLE;
          end else if (sclk_rise) begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_inc(bit_cnt_q);
            if (state_q == ST_CMD && bit_cnt_q == CMD_LAST_BIT) begin
              cmd_q   <= shift_d;
              state_q <= ST_DATA;
              if (shift_d == CMD_READ) begin
                tx_q  <= count_in;
                sdo_q <= count_in[DATA_W-1];
              end
            end else if (state_q == ST_DATA && bit_cnt_q == FRAME_LAST_BIT) begin
              sdo_q   <= 1'b0;
              state_q <= ST_EXEC;
            end
          end else if (sclk_fall && state_q == ST_DATA && cmd_q == CMD_READ &&
                       bit_cnt_q >= TX_SHIFT_START) begin
            tx_q  <= tx_q << 1;
            sdo_q <= tx_q[DATA_W-2];
          end
        end
        ST_EXEC: begin
          state_q <= ST_WAIT_CS;
          case (cmd_q)
            CMD_LOAD: begin
              load_value_q  <= shift_q;
              load_strobe_q <= 1'b1;
            end
            CMD_CTRL: begin
              cnt_en_q <= shift_q[0];
              up_dn_q  <= shift_q[1];
            end
            CMD_READ: begin
              sdo_q <= 1'b0;
            end
            default: begin
              frame_err_q <= 1'b1;
            end
          endcase
        end
        default: begin
          state_q <= ST_WAIT_CS;
        end
      endcase
    end
  end

  assign sdo_out     = sdo_q;
  assign load_strobe = load_strobe_q;
  assign load_value  = load_value_q;
  assign cnt_en      = cnt_en_q;
  assign up_dn       = up_dn_q;
  assign frame_err   = frame_err_q;
  assign busy        = (state_q == ST_CMD) || (state_q == ST_DATA) || (state_q == ST_EXEC);

endmodule

// File: doc/counter_prog_rx.md
Name: counter_prog_rx

Overview:
- Serial programming receiver for the 8-bit programmable counter.
- Takes a 3-wire host interface (sclk/sdi/cs_n, mode 0, MSB first) from the pins, decodes 16-bit frames, and drives the counter's load, enable and direction controls.
- Returns a snapshot of the live count on sdo for READ frames.
- Sits between ui_in pins and the counter core inside the top-level wrapper.

Parameters:
- SYNC_STAGES, 2, flip-flops in each input synchronizer (min 2)
- DATA_W, 8, counter and data-field width

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- sclk_in  in  1  host serial clock, asynchronous to clk, f ≤ f_clk/4
- sdi_in  in  1  host serial data in
- cs_n_in  in  1  host frame select, active low
- count_in  in  DATA_W  live counter value, for READ snapshot
- sdo_out  out  1  serial data out to host
- load_strobe  out  1  one-cycle pulse: counter loads load_value
- load_value  out  DATA_W  preset value, held until next LOAD
- cnt_en  out  1  counter enable
- up_dn  out  1  1 = count up, 0 = count down
- frame_err  out  1  one-cycle pulse on aborted or unknown frame
- busy  out  1  frame in progress

Behaviour:
- Input synchronization
  - sclk_in, sdi_in and cs_n_in each pass through SYNC_STAGES flops.
  - Edge detect runs on the synced sclk and cs_n.
  - sdi is sampled on a synced sclk rise; sdo updates on a synced sclk fall.
- Frame format: 8-bit cmd, then 8-bit data, both MSB first, 16 sclk rises total.
- Commands
  - 0x01 LOAD: load_value <= data; load_strobe = 1 for one cycle.
  - 0x02 CTRL: cnt_en <= data[0]; up_dn <= data[1]; data[7:2] ignored.
  - 0x80 READ: data bits ignored; sdo shifts out the count snapshot.
  - Any other cmd: no effect; frame_err pulses in the EXEC cycle.
- FSM states: WAIT_CS, IDLE, CMD, DATA, EXEC
  - WAIT_CS: wait for synced cs_n = 1, then go to IDLE. This is the reset state, so a frame already in progress at reset release is ignored.
  - IDLE: on synced cs_n fall, go to CMD; clear bit_cnt and shift register.
  - CMD: shift in on each sclk rise. After the 8th rise, latch cmd and go to DATA.
  - On CMD→DATA with cmd == 0x80: tx_shift <= count_in (snapshot taken in the same cycle) and sdo_out = tx_shift[7] immediately. Each following sclk fall shifts left.
  - DATA: after the 8th rise, go to EXEC.
  - EXEC: one cycle. Apply the command with registered outputs, so load_strobe, cnt_en and up_dn change in the cycle after the 16th rise is detected. Then go to WAIT_CS.
- Abort
  - Synced cs_n rise in CMD or DATA → frame_err for one cycle, nothing applied, go to IDLE.
  - If that cs_n rise coincides with the 16th sclk rise, abort wins.
- sclk edges in IDLE or WAIT_CS are ignored. Extra bits beyond 16 are ignored until cs_n goes high.
- sdo_out = 0 whenever not in a READ DATA phase.
- busy = 1 in CMD, DATA and EXEC; otherwise 0.
- Reset values: load_strobe 0, load_value 0, cnt_en 0, up_dn 1, frame_err 0, sdo_out 0, busy 0, state WAIT_CS.
- Reset mid-frame discards all partial state. The next frame requires cs_n high, then a fresh fall.
- bit_cnt is 4 bits. It saturates at 15 and is never reused across frames.

Decomposition:
- Package counter_prog_pkg holds:
  - cmd constants CMD_LOAD = 8'h01, CMD_CTRL = 8'h02, CMD_READ = 8'h80
  - the state enum
  - FRAME_BITS = 16
  - reset defaults (UP_DN_RST = 1)
- Sub-module sync_edge: parameterized N-flop synchronizer with registered rise/fall outputs.
  - Instantiated for sclk and cs_n.
  - sdi uses the same module with its edge outputs unused.

Test Plan:
- Reset, then frame 0x01,0xA5 → load_strobe high exactly one cycle, load_value = 0xA5, frame_err never asserts.
- Frame 0x02,0x01, then 0x02,0x02 → cnt_en=1/up_dn=0 after the first frame; cnt_en=0/up_dn=1 after the second; no load_strobe.
- count_in = 0x3C, frame 0x80,0x00 → host samples 0,0,1,1,1,1,0,0 on sdo over data rises 9–16; count_in changes mid-frame do not alter the shifted value.
- cs_n raised after 11 bits of a LOAD 0x7E → frame_err one cycle, load_value unchanged; the next full LOAD 0x12 succeeds.
- Unknown cmd 0x55 → frame_err one cycle in EXEC; outputs unchanged. rst asserted after 6 bits of a LOAD, released with cs_n still low, remaining bits sent → nothing happens until cs_n high→low, then a new frame works.
